// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle control FSM and the ALU decode block.
package mc_ctrl_fsm_pkg;

    localparam int unsigned OPC_W = 7;
    localparam int unsigned ST_W  = 4;
    localparam int unsigned SEL_W = 2;

    // FSM state encodings
    localparam logic [ST_W-1:0] ST_IDLE   = 4'd0;
    localparam logic [ST_W-1:0] ST_FETCH  = 4'd1;
    localparam logic [ST_W-1:0] ST_DECODE = 4'd2;
    localparam logic [ST_W-1:0] ST_EXEC   = 4'd3;
    localparam logic [ST_W-1:0] ST_ADDR   = 4'd4;
    localparam logic [ST_W-1:0] ST_MEM_RD = 4'd5;
    localparam logic [ST_W-1:0] ST_MEM_WR = 4'd6;
    localparam logic [ST_W-1:0] ST_WB_ALU = 4'd7;
    localparam logic [ST_W-1:0] ST_WB_MEM = 4'd8;
    localparam logic [ST_W-1:0] ST_BRANCH = 4'd9;
    localparam logic [ST_W-1:0] ST_JUMP   = 4'd10;
    localparam logic [ST_W-1:0] ST_HALT   = 4'd11;

    // Supported major opcodes (IR[6:0])
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

    // ALU class codes the FSM forces outside of EXEC/ADDR
    localparam logic [OPC_W-1:0] ALU_ADD = 7'b0000011;
    localparam logic [OPC_W-1:0] ALU_SUB = 7'b1100011;

    // Next-PC select
    localparam logic [SEL_W-1:0] PC_SEL_INC = 2'b00;
    localparam logic [SEL_W-1:0] PC_SEL_TGT = 2'b01;
    localparam logic [SEL_W-1:0] PC_SEL_ALU = 2'b10;

    // ALU operand A select
    localparam logic [SEL_W-1:0] SRC_A_PC   = 2'b00;
    localparam logic [SEL_W-1:0] SRC_A_RS1  = 2'b01;
    localparam logic [SEL_W-1:0] SRC_A_ZERO = 2'b10;

    // ALU operand B select
    localparam logic [SEL_W-1:0] SRC_B_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRC_B_FOUR = 2'b01;
    localparam logic [SEL_W-1:0] SRC_B_IMM  = 2'b10;

    // Register-file writeback source
    localparam logic [SEL_W-1:0] WB_SEL_ALU = 2'b00;
    localparam logic [SEL_W-1:0] WB_SEL_MEM = 2'b01;
    localparam logic [SEL_W-1:0] WB_SEL_PC  = 2'b10;

    // Full control word driven toward the datapath
    typedef struct packed {
        logic             mem_req;
        logic             mem_we;
        logic             iord;
        logic             ir_we;
        logic             pc_we;
        logic             rf_we;
        logic             tgt_we;
        logic             illegal;
        logic [SEL_W-1:0] pc_sel;
        logic [SEL_W-1:0] alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] wb_sel;
        logic [OPC_W-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    // Opcode dispatch out of DECODE; unknown opcodes park in HALT
    function automatic logic [ST_W-1:0] decode_next(input logic [OPC_W-1:0] opc);
        logic [ST_W-1:0] nxt;
        case (opc)
            OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_JALR: nxt = ST_EXEC;
            OPC_LOAD, OPC_STORE:                              nxt = ST_ADDR;
            OPC_BRANCH:                                       nxt = ST_BRANCH;
            OPC_JAL:                                          nxt = ST_JUMP;
            default:                                          nxt = ST_HALT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control bus between the multi-cycle FSM and the datapath / memory port.
interface mc_ctrl_fsm_if;
    import mc_ctrl_fsm_pkg::*;

    logic [OPC_W-1:0] ir_opcode;
    logic             br_taken;
    logic             mem_ack;

    logic             mem_req;
    logic             mem_we;
    logic             iord;
    logic             ir_we;
    logic             pc_we;
    logic             rf_we;
    logic             tgt_we;
    logic             illegal;
    logic [SEL_W-1:0] pc_sel;
    logic [SEL_W-1:0] alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] wb_sel;
    logic [OPC_W-1:0] alu_op;
    logic [ST_W-1:0]  state;

    // Controller side
    modport master (
        input  ir_opcode, br_taken, mem_ack,
        output mem_req, mem_we, iord, ir_we, pc_we, rf_we, tgt_we, illegal,
        output pc_sel, alu_src_a, alu_src_b, wb_sel, alu_op, state
    );

    // Datapath side
    modport slave (
        output ir_opcode, br_taken, mem_ack,
        input  mem_req, mem_we, iord, ir_we, pc_we, rf_we, tgt_we, illegal,
        input  pc_sel, alu_src_a, alu_src_b, wb_sel, alu_op, state
    );

endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I-style control FSM; outputs are decoded from the state
// register so an asynchronous reset clears them without waiting for clk.
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
(
    input  logic          clk,
    input  logic          rstn,
    mc_ctrl_fsm_if.master ctl_if
);

    logic [ST_W-1:0] r_state;
    logic [ST_W-1:0] w_state_nxt;
    logic            r_run;
    ctrl_t           w_ctrl;

    // Reset-release qualifier: IDLE is held across the first edge after rstn rises
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control decode
    always_comb begin
        w_state_nxt = r_state;
        w_ctrl      = CTRL_NONE;

        case (r_state)
            ST_IDLE: begin
                if (r_run) begin
                    w_state_nxt = ST_FETCH;
                end
            end

            ST_FETCH: begin
                w_ctrl.mem_req   = 1'b1;
                w_ctrl.iord      = 1'b0;
                w_ctrl.alu_src_a = SRC_A_PC;
                w_ctrl.alu_src_b = SRC_B_FOUR;
                w_ctrl.alu_op    = ALU_ADD;
                if (ctl_if.mem_ack) begin
                    w_ctrl.ir_we  = 1'b1;
                    w_ctrl.pc_we  = 1'b1;
                    w_ctrl.pc_sel = PC_SEL_INC;
                    w_state_nxt   = ST_DECODE;
                end
            end

            ST_DECODE: begin
                // Speculatively latch PC+imm as the branch/jump target
                w_ctrl.alu_src_a = SRC_A_PC;
                w_ctrl.alu_src_b = SRC_B_IMM;
                w_ctrl.alu_op    = ALU_ADD;
                w_ctrl.tgt_we    = 1'b1;
                w_state_nxt      = decode_next(ctl_if.ir_opcode);
            end

            ST_EXEC: begin
                w_ctrl.alu_op = ctl_if.ir_opcode;
                case (ctl_if.ir_opcode)
                    OPC_OP: begin
                        w_ctrl.alu_src_a = SRC_A_RS1;
                        w_ctrl.alu_src_b = SRC_B_RS2;
                    end
                    OPC_OPIMM, OPC_JALR: begin
                        w_ctrl.alu_src_a = SRC_A_RS1;
                        w_ctrl.alu_src_b = SRC_B_IMM;
                    end
                    OPC_LUI: begin
                        w_ctrl.alu_src_a = SRC_A_ZERO;
                        w_ctrl.alu_src_b = SRC_B_IMM;
                    end
                    OPC_AUIPC: begin
                        w_ctrl.alu_src_a = SRC_A_PC;
                        w_ctrl.alu_src_b = SRC_B_IMM;
                    end
                    default: begin
                        w_ctrl.alu_src_a = SRC_A_PC;
                        w_ctrl.alu_src_b = SRC_B_RS2;
                    end
                endcase
                w_state_nxt = (ctl_if.ir_opcode == OPC_JALR) ? ST_JUMP : ST_WB_ALU;
            end

            ST_WB_ALU: begin
                w_ctrl.rf_we  = 1'b1;
                w_ctrl.wb_sel = WB_SEL_ALU;
                w_state_nxt   = ST_FETCH;
            end

            ST_ADDR: begin
                w_ctrl.alu_src_a = SRC_A_RS1;
                w_ctrl.alu_src_b = SRC_B_IMM;
                w_ctrl.alu_op    = ctl_if.ir_opcode;
                w_state_nxt      = (ctl_if.ir_opcode == OPC_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            end

            ST_MEM_RD: begin
                w_ctrl.mem_req = 1'b1;
                w_ctrl.iord    = 1'b1;
                if (ctl_if.mem_ack) begin
                    w_state_nxt = ST_WB_MEM;
                end
            end

            ST_MEM_WR: begin
                w_ctrl.mem_req = 1'b1;
                w_ctrl.mem_we  = 1'b1;
                w_ctrl.iord    = 1'b1;
                if (ctl_if.mem_ack) begin
                    w_state_nxt = ST_FETCH;
                end
            end

            ST_WB_MEM: begin
                w_ctrl.rf_we  = 1'b1;
                w_ctrl.wb_sel = WB_SEL_MEM;
                w_state_nxt   = ST_FETCH;
            end

            ST_BRANCH: begin
                w_ctrl.alu_src_a = SRC_A_RS1;
                w_ctrl.alu_src_b = SRC_B_RS2;
                w_ctrl.alu_op    = ALU_SUB;
                w_ctrl.pc_we     = ctl_if.br_taken;
                w_ctrl.pc_sel    = PC_SEL_TGT;
                w_state_nxt      = ST_FETCH;
            end

            ST_JUMP: begin
                // Link PC into rd; JAL uses the DECODE target, JALR the EXEC result
                w_ctrl.rf_we  = 1'b1;
                w_ctrl.wb_sel = WB_SEL_PC;
                w_ctrl.pc_we  = 1'b1;
                w_ctrl.pc_sel = (ctl_if.ir_opcode == OPC_JALR) ? PC_SEL_ALU : PC_SEL_TGT;
                w_state_nxt   = ST_FETCH;
            end

            ST_HALT: begin
                w_ctrl.illegal = 1'b1;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Drive the control bus
    assign ctl_if.mem_req   = w_ctrl.mem_req;
    assign ctl_if.mem_we    = w_ctrl.mem_we;
    assign ctl_if.iord      = w_ctrl.iord;
    assign ctl_if.ir_we     = w_ctrl.ir_we;
    assign ctl_if.pc_we     = w_ctrl.pc_we;
    assign ctl_if.rf_we     = w_ctrl.rf_we;
    assign ctl_if.tgt_we    = w_ctrl.tgt_we;
    assign ctl_if.illegal   = w_ctrl.illegal;
    assign ctl_if.pc_sel    = w_ctrl.pc_sel;
    assign ctl_if.alu_src_a = w_ctrl.alu_src_a;
    assign ctl_if.alu_src_b = w_ctrl.alu_src_b;
    assign ctl_if.wb_sel    = w_ctrl.wb_sel;
    assign ctl_if.alu_op    = w_ctrl.alu_op;
    assign ctl_if.state     = r_state;

endmodule
